// File: rtl/fp_pkg.sv
// Shared widths, state encoding and saturation limits for the linear-to-float converter.
package fp_pkg;

  localparam int D_W = 12;
  localparam int E_W = 3;
  localparam int F_W = 4;

  localparam logic [E_W-1:0] E_MAX = 3'd7;
  localparam logic [F_W-1:0] F_MAX = 4'd15;

  // The one input value whose magnitude does not fit in D_W-1 bits.
  localparam logic [D_W-1:0] D_MIN_NEG = 12'h800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } state_e;

  function automatic logic [D_W-1:0] abs_mag(input logic [D_W-1:0] d);
    return d[D_W-1] ? (~d + 12'd1) : d;
  endfunction

endpackage

// File: rtl/round.sv
// Combinational round-half-up of a 4-bit significand, carrying into the
// exponent and clamping at the largest representable value.
module round
  import fp_pkg::*;
(
  input  logic [E_W-1:0] e_in,
  input  logic [F_W-1:0] f_in,
  input  logic           fifth,
  output logic [E_W-1:0] e_out,
  output logic [F_W-1:0] f_out
);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    e_out = e_in;
    f_out = f_in;
    if (fifth) begin
      if (f_in != F_MAX) begin
        f_out = f_in + 4'd1;
      end else if (e_in != E_MAX) begin
        // 1.111 rounds up to 10.000, renormalised as 1.000 with the next exponent.
        e_out = e_in + 3'd1;
        f_out = 4'd8;
      end
    end
  end

endmodule

// File: rtl/fp_convert_ctrl.sv
// Sequential converter from a 12-bit two's-complement value to sign/3-bit
// exponent/4-bit significand: normalise one bit per cycle, then round.
module fp_convert_ctrl
  import fp_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [D_W-1:0] D,
  output logic           busy,
  output logic           done,
  output logic           S,
  output logic [E_W-1:0] E,
  output logic [F_W-1:0] F
);

  state_e         state_q, state_d;
  logic           sign_q, sign_d;
  logic [D_W-1:0] mag_q, mag_d;
  logic [E_W-1:0] exp_q, exp_d;
  logic           sat_q, sat_d;
  logic           sat_wait_q, sat_wait_d;
  logic           s_q, s_d;
  logic [E_W-1:0] e_q, e_d;
  logic [F_W-1:0] f_q, f_d;
  logic           done_q, done_d;

  logic [E_W-1:0] rnd_e;
  logic [F_W-1:0] rnd_f;

  round u_round (
    .e_in  (exp_q),
    .f_in  (mag_q[10:7]),
    .fifth (mag_q[6]),
    .e_out (rnd_e),
    .f_out (rnd_f)
  );

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    exp_d      = exp_q;
    sat_d      = sat_q;
    sat_wait_d = sat_wait_q;
    s_d        = s_q;
    e_d        = e_q;
    f_d        = f_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = D[D_W-1];
          mag_d  = abs_mag(D);
          exp_d  = E_MAX;
          if (D == D_MIN_NEG) begin
            sat_d      = 1'b1;
            sat_wait_d = 1'b1;
            state_d    = ROUND;
          end else begin
            sat_d   = 1'b0;
            state_d = NORM;
          end
        end
      end

      NORM: begin
        // Bit 11 is only ever set for the saturating input, which bypasses NORM.
        if (mag_q[11:10] != 2'b00 || exp_q == '0) begin
          state_d = ROUND;
        end else begin
          mag_d = {mag_q[10:0], 1'b0};
          exp_d = exp_q - 3'd1;
        end
      end

      ROUND: begin
        // Saturation skips NORM, so it idles one cycle here to keep latency at two.
        if (sat_wait_q) begin
          sat_wait_d = 1'b0;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (sat_q) begin
            s_d   = 1'b1;
            e_d   = E_MAX;
            f_d   = F_MAX;
            sat_d = 1'b0;
          end else begin
            s_d = sign_q;
            e_d = rnd_e;
            f_d = rnd_f;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      exp_q      <= '0;
      sat_q      <= 1'b0;
      sat_wait_q <= 1'b0;
      s_q        <= 1'b0;
      e_q        <= '0;
      f_q        <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      exp_q      <= exp_d;
      sat_q      <= sat_d;
      sat_wait_q <= sat_wait_d;
      s_q        <= s_d;
      e_q        <= e_d;
      f_q        <= f_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign S    = s_q;
  assign E    = e_q;
  assign F    = f_q;

endmodule

// File: tb/tb_fp_convert_ctrl.sv
// Scoreboard bench for fp_convert_ctrl: expected results and latencies are
// queued at the accepting edge and compared when done pulses.
module tb_fp_convert_ctrl;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] D;
  logic        busy, done, S;
  logic [2:0]  E;
  logic [3:0]  F;

  fp_convert_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .D     (D),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .E     (E),
    .F     (F)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int e;
    int f;
    int lat;
    int k;
    int d;
  } exp_t;

  exp_t sb[$];
  exp_t got_x;
  int   cyc = 0;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference: locate the leading one directly instead of stepping a shifter.
  function automatic exp_t model(input logic [11:0] d, input int k);
    exp_t r;
    int v, mag, p, n, m, fifth;
    r.d = int'(d);
    r.k = k;
    if (d == 12'h800) begin
      r.s = 1; r.e = 7; r.f = 15; r.lat = 2;
      return r;
    end
    v   = $signed(d);
    mag = (v < 0) ? -v : v;
    p   = -1;
    for (int i = 0; i <= 10; i++) if (mag[i]) p = i;
    n = (p < 0) ? 7 : (((10 - p) > 7) ? 7 : (10 - p));
    m = mag << n;
    r.s   = (v < 0) ? 1 : 0;
    r.e   = 7 - n;
    r.f   = (m >> 7) & 15;
    fifth = (m >> 6) & 1;
    if (fifth == 1) begin
      if (r.f < 15) r.f = r.f + 1;
      else if (r.e < 7) begin r.e = r.e + 1; r.f = 8; end
    end
    r.lat = n + 2;
    return r;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (prev_done) check("done_single_cycle", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        got_x = sb.pop_front();
        check($sformatf("S[%03h]", got_x.d), 32'(S), got_x.s);
        check($sformatf("E[%03h]", got_x.d), 32'(E), got_x.e);
        check($sformatf("F[%03h]", got_x.d), 32'(F), got_x.f);
        check($sformatf("latency[%03h]", got_x.d), cyc - got_x.k, got_x.lat);
      end
    end
    prev_done <= done;
  end

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_sb_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    check("done_timeout", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic convert(input logic [11:0] d);
    exp_t m;
    wait_idle();
    D = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    m = model(d, cyc);
    sb.push_back(m);
    start = 1'b0;
    D = 12'($urandom);
    wait_sb_empty(20);
    repeat (3) @(negedge clk);
    check("hold_S", 32'(S), m.s);
    check("hold_E", 32'(E), m.e);
    check("hold_F", 32'(F), m.f);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1;
    start = 1'b0;
    D = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_S", 32'(S), 32'd0);
    check("reset_E", 32'(E), 32'd0);
    check("reset_F", 32'(F), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    convert(12'h07D);
    convert(12'h7FF);
    convert(12'h800);
    convert(12'hFFF);
    convert(12'h000);
    convert(12'h00A);
    for (int i = 0; i < 8; i++) convert(12'($urandom_range(0, 4095)));

    // Start pulsed during NORM must be dropped.
    wait_idle();
    D = 12'h00A;
    start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(12'h00A, cyc));
    start = 1'b0;
    repeat (2) @(negedge clk);
    D = 12'h123;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("busy_during_norm", 32'(busy), 32'd1);
      @(negedge clk);
    end
    wait_sb_empty(20);
    repeat (12) @(negedge clk);
    check("busy_after_ignored_start", 32'(busy), 32'd0);

    // Reset mid-NORM aborts the conversion with no done pulse.
    wait_idle();
    D = 12'h07D;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_S", 32'(S), 32'd0);
    check("midrst_E", 32'(E), 32'd0);
    check("midrst_F", 32'(F), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // Reset wins over a simultaneous start.
    D = 12'h07D;
    start = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_vs_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_vs_start_idle", 32'(busy), 32'd0);

    // Start held high across done: second conversion accepted the edge after done.
    wait_idle();
    D = 12'h07D;
    start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    sb.push_back(model(12'h07D, k));
    sb.push_back(model(12'h00A, k + 7));
    D = 12'h00A;
    for (int i = 0; i < 20 && sb.size() > 1; i++) @(negedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_sb_empty(30);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fp_convert_ctrl.md
FP_CONVERT_CTRL -- requirements
Module: fp_convert_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed (D 12 b, E 3 b, F 4 b) and taken from fp_pkg.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request conversion of D; sampled only in IDLE.
REQ-005 D  input  12  two's-complement linear value to convert.
REQ-006 busy  output  1  high while a conversion is in progress (state != IDLE).
REQ-007 done  output  1  registered one-cycle pulse; S/E/F are valid from that edge on.
REQ-008 S  output  1  sign of result.
REQ-009 E  output  3  exponent of result.
REQ-010 F  output  4  significand of result.

Function
REQ-011 The FSM SHALL have the states IDLE, NORM and ROUND, with NORM and ROUND counted as busy.
REQ-012 IDLE with start=1 at edge k SHALL capture the following and go to NORM:
  - sign = D[11];
  - mag = |D| as 12-bit unsigned;
  - exp counter = 7.
REQ-013 The value D=0x800 (-2048) SHALL set a saturate flag at edge k and go directly to ROUND.
REQ-014 Each NORM cycle with mag[10]=0 and exp!=0 SHALL shift mag left by 1 (zero fill) and decrement exp.
REQ-015 NORM SHALL go to ROUND when mag[10]=1 or exp=0, with no shift that cycle.
REQ-016 ROUND SHALL form the significand as mag[10:7] and the fifth bit as mag[6].
REQ-017 ROUND SHALL round as follows:
  - fifth=0: the result SHALL be the truncated value;
  - fifth=1 and F!=15: F SHALL be F+1;
  - fifth=1, F=15 and E!=7: the result SHALL be E+1, F=8;
  - fifth=1, F=15 and E=7: the result SHALL be E=7, F=15 unchanged.
REQ-018 A saturated conversion SHALL output E=7, F=15, S=1.
REQ-019 ROUND SHALL register S/E/F, assert done for exactly one cycle and return to IDLE.
REQ-020 Latency SHALL be exact:
  - normal conversion with N shifts (0..7): done at edge k+N+2, maximum k+9;
  - saturated conversion: done at edge k+2.
REQ-021 start while busy SHALL be ignored, not queued.
REQ-022 start in the cycle done is high SHALL be accepted, giving back-to-back conversions.
REQ-023 S/E/F SHALL hold their last result until the next done pulse.
REQ-024 D SHALL be sampled only at the accepting edge; later changes to D SHALL NOT affect the conversion in flight.
REQ-025 D=0 SHALL yield S=0, E=0, F=0 after 7 shifts.

Reset
REQ-026 rst=1 at an edge SHALL force the following in any state, including mid-NORM:
  - state IDLE;
  - busy=0, done=0;
  - S=0, E=0, F=0;
  - internal mag, exp and saturate flag cleared.
REQ-027 rst SHALL take priority over start in the same cycle, and the start SHALL be discarded.

Structure
REQ-028 fp_pkg SHALL hold the following shared definitions:
  - D_W=12, E_W=3, F_W=4;
  - the state encoding (IDLE/NORM/ROUND);
  - the saturation constants E_MAX=7, F_MAX=15.
REQ-029 The rounding step SHALL instantiate the existing combinational sub-module round, fed with the E counter, mag[10:7] and mag[6].
REQ-030 The round outputs SHALL be registered in ROUND, and no other sub-module SHALL be used.

Verification
REQ-031 D=0x07D, start at edge k -> 4 shifts, done at k+6, S=0, E=4, F=8 (exercises the overflow carry into E).
REQ-032 D=0x7FF -> done at k+2, S=0, E=7, F=15 (rounding clamps at the maximum); D=0x800 -> done at k+2, S=1, E=7, F=15 (saturation).
REQ-033 D=0xFFF -> done at k+9, S=1, E=0, F=1; D=0x000 -> done at k+9, S=0, E=0, F=0.
REQ-034 D=0x00A accepted, then start pulsed with D=0x123 during NORM -> output S=0, E=0, F=10 only; busy stays high until done.
REQ-035 D=0x07D accepted, rst asserted at edge k+3 -> at the next clock busy=0, done=0, S/E/F=0, and no done pulse follows.
REQ-036 Start held high across a done pulse with D=0x07D then D=0x00A -> two done pulses 6 cycles then 9 cycles apart, giving (0,4,8) then (0,0,10).
